// File: rtl/median_arbiter.sv
// Round-robin arbiter sharing one 9-pixel median engine among NREQ window requesters.
// Optional WAIT timeout (ERR pulse) is built only when MEDARB_TIMEOUT_EN is defined.
module median_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ*WIDTH-1:0]   i_di,
  output logic [NREQ-1:0]         o_gnt,
  output logic [3:0]              o_pix_idx,
  output logic [WIDTH-1:0]        o_mdi,
  output logic                    o_mdsi,
  input  logic [WIDTH-1:0]        i_mdo,
  input  logic                    i_mdso,
  output logic [WIDTH-1:0]        o_res,
  output logic [$clog2(NREQ)-1:0] o_res_id,
  output logic                    o_res_vld,
  output logic                    o_busy,
  output logic                    o_err
);

  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]       r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_owner;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_res;
  logic [IDW-1:0]   r_res_id;
  logic             r_res_vld;

  logic             w_any;
  logic [IDW-1:0]   w_winner;
  logic [IDW-1:0]   w_next_ptr;
  logic [IDW:0]     w_scan;
  logic [WIDTH-1:0] w_slice;
  logic             w_timeout;

  // First set request at or above the pointer, wrapping; one extra bit avoids overflow.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_scan   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_scan = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_scan >= (IDW+1)'(NREQ)) begin
        w_scan = w_scan - (IDW+1)'(NREQ);
      end
      if (!w_any && i_req[w_scan[IDW-1:0]]) begin
        w_any    = 1'b1;
        w_winner = w_scan[IDW-1:0];
      end
    end
  end

  assign w_next_ptr = (w_winner == IDW'(NREQ-1)) ? '0 : w_winner + IDW'(1);

  always_comb begin
    w_slice = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == IDW'(i)) begin
        w_slice = i_di[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_res     <= '0;
      r_res_id  <= '0;
      r_res_vld <= 1'b0;
    end else begin
      r_res_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_winner;
            r_ptr   <= w_next_ptr;
            r_cnt   <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (r_cnt == 4'd8) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_WAIT: begin
          // A done strobe on the last allowed cycle still wins over the timeout.
          if (i_mdso) begin
            r_res     <= i_mdo;
            r_res_id  <= r_owner;
            r_res_vld <= 1'b1;
            r_state   <= S_IDLE;
          end else if (w_timeout) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MEDARB_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);

  logic [TCW-1:0] r_wcnt;
  logic           r_err;

  assign w_timeout = (r_state == S_WAIT) && !i_mdso && (r_wcnt == TCW'(TIMEOUT - 1));

  // r_wcnt holds the number of WAIT cycles already spent; it is zero on WAIT entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (r_state != S_WAIT) begin
        r_wcnt <= '0;
      end else begin
        r_wcnt <= r_wcnt + TCW'(1);
      end
    end
  end

  assign o_err = r_err;
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign o_err            = 1'b0;
`endif

  assign o_gnt     = (r_state == S_LOAD) ? (NREQ'(1) << r_owner) : '0;
  assign o_mdsi    = (r_state == S_LOAD);
  assign o_pix_idx = (r_state == S_LOAD) ? r_cnt : 4'd0;
  assign o_mdi     = (r_state == S_LOAD) ? w_slice : '0;
  assign o_busy    = (r_state != S_IDLE);
  assign o_res     = r_res;
  assign o_res_id  = r_res_id;
  assign o_res_vld = r_res_vld;

endmodule

// File: tb/tb_median_arbiter.sv
// Directed bench for median_arbiter: requester front-end and median engine models plus a result scoreboard.
// Timeout scenarios run only when MEDARB_TIMEOUT_EN is defined.
module tb_median_arbiter;

  localparam int WIDTH   = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int IDW     = 2;

  logic                  clk = 1'b0;
  logic                  i_rst;
  logic [NREQ-1:0]       i_req;
  logic [NREQ*WIDTH-1:0] i_di;
  logic [NREQ-1:0]       o_gnt;
  logic [3:0]            o_pix_idx;
  logic [WIDTH-1:0]      o_mdi;
  logic                  o_mdsi;
  logic [WIDTH-1:0]      i_mdo;
  logic                  i_mdso;
  logic [WIDTH-1:0]      o_res;
  logic [IDW-1:0]        o_res_id;
  logic                  o_res_vld;
  logic                  o_busy;
  logic                  o_err;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] res;
  } exp_t;

  exp_t sbQ[$];
  int nAssert   = 0;
  int nFail     = 0;
  int vldCount  = 0;
  int errCount  = 0;
  int mdsiCount = 0;

  logic [NREQ-1:0][WIDTH-1:0] pixBase;
  logic [NREQ-1:0][WIDTH-1:0] pixStep;
  bit engRespond  = 1'b1;
  bit engSpurious = 1'b0;
  int engDelay    = 3;

  logic [9*WIDTH-1:0] engPix;
  int                 engN    = 0;
  int                 engWait = -1;
  logic [WIDTH-1:0]   engMed;

  median_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_di(i_di),
    .o_gnt(o_gnt), .o_pix_idx(o_pix_idx), .o_mdi(o_mdi), .o_mdsi(o_mdsi),
    .i_mdo(i_mdo), .i_mdso(i_mdso),
    .o_res(o_res), .o_res_id(o_res_id), .o_res_vld(o_res_vld),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Front ends present pixel base + step*PIX_IDX on their slice.
  always_comb begin
    i_di = '0;
    for (int r = 0; r < NREQ; r++) begin
      i_di[r*WIDTH +: WIDTH] = pixBase[r] + WIDTH'(pixStep[r] * o_pix_idx);
    end
  end

  function automatic logic [WIDTH-1:0] median9(input logic [9*WIDTH-1:0] bus);
    logic [WIDTH-1:0] v[9];
    logic [WIDTH-1:0] t;
    for (int i = 0; i < 9; i++) v[i] = bus[i*WIDTH +: WIDTH];
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
      end
    end
    return v[4];
  endfunction

  function automatic exp_t mkExp(input int id, input int res);
    exp_t e;
    e.id  = IDW'(id);
    e.res = WIDTH'(res);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] req);
    i_req = req;
  endtask

  // Median engine: collects 9 strobed pixels, answers engDelay WAIT cycles later.
  initial begin
    i_mdso = 1'b0;
    i_mdo  = '0;
    forever begin
      @(negedge clk);
      i_mdso = 1'b0;
      if (i_rst) begin
        engN    = 0;
        engWait = -1;
      end else begin
        if (engWait > 0) begin
          engWait--;
          if (engWait == 0) begin
            i_mdso  = 1'b1;
            i_mdo   = engMed;
            engWait = -1;
          end
        end
        if (o_mdsi && engN < 9) begin
          engPix[engN*WIDTH +: WIDTH] = o_mdi;
          engN++;
          if (engSpurious && engN == 4) begin
            i_mdso = 1'b1;
            i_mdo  = 8'hEE;
          end
          if (engN == 9) begin
            engN   = 0;
            engMed = median9(engPix);
            if (engRespond) engWait = engDelay;
          end
        end
      end
    end
  end

  // Result monitor: every RES_VLD pops the scoreboard; grants must stay one-hot.
  always @(negedge clk) begin
    exp_t e;
    if (o_mdsi) mdsiCount++;
    if (o_err) errCount++;
    if (o_gnt !== '0) checkOutput("gnt_onehot", 32'($onehot(o_gnt)), 1);
    if (o_res_vld) begin
      vldCount++;
      if (sbQ.size() == 0) begin
        checkOutput("res_vld_unexpected", o_res_vld, 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("res_value", o_res, e.res);
        checkOutput("res_id", o_res_id, e.id);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic doReset(input string tag, input logic [NREQ-1:0] req);
    i_rst = 1'b1;
    i_req = req;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_gnt"}, o_gnt, 0);
    checkOutput({tag, "_busy"}, o_busy, 0);
    checkOutput({tag, "_mdsi"}, o_mdsi, 0);
    checkOutput({tag, "_pix_idx"}, o_pix_idx, 0);
    checkOutput({tag, "_res"}, o_res, 0);
    checkOutput({tag, "_res_id"}, o_res_id, 0);
    checkOutput({tag, "_res_vld"}, o_res_vld, 0);
    checkOutput({tag, "_err"}, o_err, 0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
  endtask

  // Call so that the next negedge falls in the first LOAD cycle.
  task automatic checkLoad(input string tag, input int owner, input int dropAt, input logic [NREQ-1:0] newReq);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      checkOutput({tag, "_gnt"}, o_gnt, 32'(1) << owner);
      checkOutput({tag, "_pix_idx"}, o_pix_idx, k);
      checkOutput({tag, "_mdi"}, o_mdi, (int'(pixBase[owner]) + int'(pixStep[owner]) * k) & 255);
      checkOutput({tag, "_mdsi"}, o_mdsi, 1);
      if (k == dropAt) i_req = newReq;
    end
  endtask

  task automatic checkWait1(input string tag);
    @(negedge clk);
    checkOutput({tag, "_wait_gnt"}, o_gnt, 0);
    checkOutput({tag, "_wait_mdsi"}, o_mdsi, 0);
    checkOutput({tag, "_wait_mdi"}, o_mdi, 0);
    checkOutput({tag, "_wait_busy"}, o_busy, 1);
  endtask

  task automatic waitVld(input string tag, input int maxCyc, output int n);
    int start;
    start = vldCount;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (vldCount == start && n < maxCyc);
    checkOutput({tag, "_vld_seen"}, vldCount - start, 1);
  endtask

  initial begin
    int n;
    int startV;
    int startM;
    int startE;

    for (int r = 0; r < NREQ; r++) begin
      pixBase[r] = WIDTH'(r + 96);
      pixStep[r] = WIDTH'(1);
    end
    i_req = '0;
    doReset("rst0", 4'b0000);

    // Single requester 2 with pixels 10..90, engine answers 41 cycles after LOAD.
    $display("[TB] single request, median 50");
    pixBase[2] = 8'd10;
    pixStep[2] = 8'd10;
    engDelay   = 41;
    applyStimulus(4'b0100);
    sbQ.push_back(mkExp(2, 50));
    @(posedge clk);
    checkLoad("t1", 2, 0, 4'b0000);
    checkWait1("t1");
    waitVld("t1", 60, n);
    checkOutput("t1_vld_latency", n, 41);
    checkOutput("t1_busy_at_vld", o_busy, 0);
    checkOutput("t1_res", o_res, 50);
    checkOutput("t1_res_id", o_res_id, 2);
    @(negedge clk);
    checkOutput("t1_vld_single", o_res_vld, 0);
    checkOutput("t1_res_held", o_res, 50);

    // All requesters held: rotation 0,1,2,3,0 from the reset pointer.
    $display("[TB] all requesters, rotation");
    doReset("rst1", 4'b0000);
    pixBase[2] = 8'd98;
    pixStep[2] = 8'd1;
    engDelay   = 3;
    for (int g = 0; g < 5; g++) sbQ.push_back(mkExp(g % 4, 100 + (g % 4)));
    startM = mdsiCount;
    applyStimulus(4'b1111);
    for (int g = 0; g < 5; g++) begin
      waitVld("t2", 40, n);
      checkOutput("t2_res_id", o_res_id, g % 4);
      if (g == 4) begin
        applyStimulus(4'b0000);
      end else begin
        @(negedge clk);
        checkOutput("t2_next_gnt", o_gnt, 32'(1) << ((g + 1) % 4));
      end
    end
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t2_idle", o_busy, 0);
    checkOutput("t2_mdsi_cycles", mdsiCount - startM, 45);

    // Requester 0 drops at LOAD cycle 3 while requester 3 rises.
    $display("[TB] request drop during LOAD");
    applyStimulus(4'b0001);
    sbQ.push_back(mkExp(0, 100));
    startM = mdsiCount;
    @(posedge clk);
    checkLoad("t3", 0, 3, 4'b1000);
    #1;
    checkOutput("t3_mdsi_cycles", mdsiCount - startM, 9);
    sbQ.push_back(mkExp(3, 103));
    checkWait1("t3");
    waitVld("t3a", 40, n);
    checkOutput("t3_res_id0", o_res_id, 0);
    checkOutput("t3_gnt_at_vld", o_gnt, 0);
    @(negedge clk);
    checkOutput("t3_gnt3", o_gnt, 4'b1000);
    applyStimulus(4'b0000);
    waitVld("t3b", 40, n);
    checkOutput("t3_res3", o_res, 103);

    // Spurious MDSO in LOAD, then reset at WAIT cycle 10.
    $display("[TB] spurious strobe and reset during WAIT");
    engRespond  = 1'b0;
    engSpurious = 1'b1;
    applyStimulus(4'b0010);
    @(posedge clk);
    checkLoad("t4", 1, 0, 4'b0000);
    checkWait1("t4");
    repeat (9) @(posedge clk);
    #1;
    checkOutput("t4_busy_wait10", o_busy, 1);
    startV      = vldCount;
    engSpurious = 1'b0;
    engRespond  = 1'b1;
    doReset("t4_rst", 4'b1001);
    checkOutput("t4_no_vld", vldCount - startV, 0);
    sbQ.push_back(mkExp(0, 100));
    @(negedge clk);
    checkOutput("t4_idle_gnt", o_gnt, 0);
    checkOutput("t4_idle_busy", o_busy, 0);
    @(posedge clk);
    checkLoad("t4b", 0, 0, 4'b0000);
    checkWait1("t4b");
    waitVld("t4b", 40, n);

`ifdef MEDARB_TIMEOUT_EN
    // Engine silent: ERR after 64 WAIT cycles, no result.
    $display("[TB] timeout without done strobe");
    engRespond = 1'b0;
    startV = vldCount;
    startE = errCount;
    applyStimulus(4'b0100);
    @(posedge clk);
    checkLoad("t5", 2, 0, 4'b0000);
    repeat (64) @(negedge clk);
    #1;
    checkOutput("t5_err_early", errCount - startE, 0);
    checkOutput("t5_busy_wait64", o_busy, 1);
    @(negedge clk);
    checkOutput("t5_err_pulse", o_err, 1);
    checkOutput("t5_busy_err", o_busy, 0);
    @(negedge clk);
    #1;
    checkOutput("t5_err_single", o_err, 0);
    checkOutput("t5_busy_after", o_busy, 0);
    checkOutput("t5_err_count", errCount - startE, 1);
    checkOutput("t5_no_vld", vldCount - startV, 0);
    checkOutput("t5_res_kept", o_res, 100);
    checkOutput("t5_res_id_kept", o_res_id, 0);

    // Done strobe on WAIT cycle 64 is a success.
    $display("[TB] done strobe on last WAIT cycle");
    engRespond = 1'b1;
    engDelay   = 64;
    startE     = errCount;
    applyStimulus(4'b0100);
    sbQ.push_back(mkExp(2, 102));
    @(posedge clk);
    checkLoad("t6", 2, 0, 4'b0000);
    checkWait1("t6");
    waitVld("t6", 80, n);
    checkOutput("t6_vld_latency", n, 64);
    @(negedge clk);
    #1;
    checkOutput("t6_no_err", errCount - startE, 0);
    checkOutput("err_total", errCount, 1);
`else
    checkOutput("err_tied_low", errCount, 0);
`endif

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_empty", sbQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/median_arbiter.md
Name: median_arbiter

Overview:
- Shares one 9-pixel median engine between NREQ pixel-window requesters.
- Grants round-robin, streams the winner's 9 pixels into the engine with the load strobe asserted, then waits for the engine's done strobe.
- Returns the median to the requesters, tagged with the winner's index.
- Sits between the window-extraction front ends and the single median engine instance.

Parameters:
- WIDTH, 8, pixel width in bits.
- NREQ, 4, number of requesters (>= 2).
- TIMEOUT, 64, maximum WAIT cycles when MEDARB_TIMEOUT_EN is defined.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  NREQ  per-requester window-ready request, level.
- DI  in  NREQ*WIDTH  requester pixel buses; requester i on bits [i*WIDTH +: WIDTH].
- GNT  out  NREQ  one-hot grant, high for exactly 9 cycles during LOAD.
- PIX_IDX  out  4  index 0..8 of the pixel expected on the granted DI slice this cycle.
- MDI  out  WIDTH  pixel to the engine.
- MDSI  out  1  engine load strobe.
- MDO  in  WIDTH  engine result.
- MDSO  in  1  engine done strobe; MDO is valid in the same cycle.
- RES  out  WIDTH  last median result, held until the next result.
- RES_ID  out  $clog2(NREQ)  requester index that owns RES.
- RES_VLD  out  1  one-cycle pulse when RES/RES_ID update.
- BUSY  out  1  high when state != IDLE.
- ERR  out  1  one-cycle timeout pulse; tied 0 when the feature is off.

Behaviour:
- Reset values: state IDLE, round-robin pointer 0, GNT 0, PIX_IDX 0, MDSI 0, RES 0, RES_ID 0, RES_VLD 0, ERR 0.
- RST mid-LOAD or mid-WAIT aborts immediately: no RES_VLD, pointer returns to 0.
- States: IDLE, LOAD, WAIT. Count register is 4 bits.
- IDLE:
  - If any REQ bit is high, choose the first set bit scanning from the pointer upward, wrapping modulo NREQ.
  - Register the owner, set pointer = owner+1 mod NREQ, count = 0, go to LOAD.
  - If no REQ bit is high, stay in IDLE.
- LOAD:
  - GNT[owner]=1, MDSI=1, PIX_IDX=count.
  - MDI = DI slice of owner, combinational pass-through with zero latency.
  - count increments each cycle; at count==8 go to WAIT.
  - Total LOAD duration is exactly 9 cycles.
- WAIT:
  - GNT=0, MDSI=0, MDI=0.
  - On MDSO=1, capture MDO into RES and owner into RES_ID, pulse RES_VLD in the next cycle, and go to IDLE.
- Latency:
  - REQ seen in IDLE at cycle t: GNT/MDSI high for cycles t+1..t+9, WAIT from t+10.
  - MDSO at cycle u: RES_VLD high at u+1, state IDLE at u+1.
  - A new grant can begin at u+2. RES_VLD and the new arbitration decision may overlap in cycle u+1.
- Boundary conditions:
  - REQ is sampled only in IDLE.
  - REQ[owner] dropping during LOAD or WAIT is ignored; the transfer completes.
  - New REQ bits during LOAD or WAIT wait for the next IDLE.
  - MDSO in IDLE or LOAD is ignored, with no state change.
  - All REQ bits high: strict rotation 0,1,2,3,0... starting from pointer 0 after reset.
  - A single requester holding REQ is granted back-to-back.
  - Pointer wraps from NREQ-1 to 0.

Optional Feature:
- MEDARB_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter resets on entry to WAIT.
  - If TIMEOUT cycles elapse with no MDSO, pulse ERR for one cycle, do not assert RES_VLD, leave RES/RES_ID unchanged, and return to IDLE.
  - The pointer still advances past the timed-out owner.
  - MDSO arriving in the same cycle the count reaches TIMEOUT counts as success.
- Undefined: WAIT has no bound, ERR is constant 0, and no counter is built.

Test Plan:
- Reset then REQ=4'b0100, DI slice 2 = 10,20..90 over PIX_IDX 0..8, engine model returns MDO=50 with MDSO 41 cycles after LOAD ends -> GNT=4'b0100 for 9 cycles, MDI sequence 10..90, RES=50, RES_ID=2, one RES_VLD pulse.
- REQ=4'b1111 held, engine median = requester index + 100 -> RES_ID order 0,1,2,3,0, RES 100,101,102,103,100, never two GNT bits high.
- REQ=4'b0001 dropped at LOAD cycle 3, with REQ[3] rising at the same time -> requester 0 still gets 9 MDSI cycles and a result; requester 3 is granted only after the next IDLE.
- Spurious MDSO pulse during LOAD, RST asserted at WAIT cycle 10 -> spurious pulse ignored; after reset GNT=0, BUSY=0, RES_VLD never pulses, next grant goes to the lowest set REQ.
- MEDARB_TIMEOUT_EN defined, TIMEOUT=64, engine never asserts MDSO -> ERR pulses once, 64 cycles into WAIT, no RES_VLD, BUSY low on the next cycle.
- MEDARB_TIMEOUT_EN defined, TIMEOUT=64, MDSO at WAIT cycle 64 -> RES_VLD pulses and ERR stays 0.
